// File: rtl/relu_maxpool2_col.sv
// rtl/relu_maxpool2_col.sv - optional ReLU (MAXPOOL_RELU_EN) + 2x2 max-pool over pairs of FP16 columns
module relu_maxpool2_col #(
    parameter int  DATA_WIDTH     = 16,
    parameter int  INPUT_COL_SIZE = 10,
    parameter int  NUM_COLS       = 10,
    localparam int OUT_COL_SIZE   = INPUT_COL_SIZE / 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      clear,
    input  logic                                      valid_in,
    input  logic [INPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] input_column,
    output logic [OUT_COL_SIZE-1:0][DATA_WIDTH-1:0]   output_column,
    output logic                                      valid_out,
    output logic                                      last_out
);

    localparam int CNT_W = (NUM_COLS > 2) ? $clog2(NUM_COLS) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NUM_COLS - 1);
    localparam logic [DATA_WIDTH-1:0] SIGN_ONLY = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {S_FIRST, S_SECOND} state_t;

    state_t                                  r_state;
    logic [CNT_W-1:0]                        r_col_cnt;
    logic [OUT_COL_SIZE-1:0][DATA_WIDTH-1:0] r_hold;
    logic [OUT_COL_SIZE-1:0][DATA_WIDTH-1:0] w_vmax;
    logic [OUT_COL_SIZE-1:0][DATA_WIDTH-1:0] w_pool;

`ifdef MAXPOOL_RELU_EN
    function automatic logic [DATA_WIDTH-1:0] act(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? '0 : x;
    endfunction

    // Post-ReLU values are non-negative, so a plain unsigned compare orders them.
    function automatic logic [DATA_WIDTH-1:0] fp_max(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        return (b > a) ? b : a;
    endfunction
`else
    function automatic logic [DATA_WIDTH-1:0] act(input logic [DATA_WIDTH-1:0] x);
        return x;
    endfunction

    // Map sign-magnitude onto a monotonic unsigned key; -0 folds onto +0.
    function automatic logic [DATA_WIDTH-1:0] fp_key(input logic [DATA_WIDTH-1:0] x);
        if (x == SIGN_ONLY)
            return SIGN_ONLY;
        else if (x[DATA_WIDTH-1])
            return ~x;
        else
            return x ^ SIGN_ONLY;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fp_max(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        return (fp_key(b) > fp_key(a)) ? b : a;
    endfunction
`endif

    always_comb begin
        w_vmax = '0;
        w_pool = '0;
        for (int k = 0; k < OUT_COL_SIZE; k++) begin
            w_vmax[k] = fp_max(act(input_column[2*k]), act(input_column[2*k+1]));
            w_pool[k] = fp_max(r_hold[k], w_vmax[k]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_FIRST;
            r_col_cnt     <= '0;
            r_hold        <= '0;
            output_column <= '0;
            valid_out     <= 1'b0;
            last_out      <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            if (clear) begin
                r_state   <= S_FIRST;
                r_col_cnt <= '0;
            end else if (valid_in) begin
                r_col_cnt <= (r_col_cnt == LAST_COL) ? '0 : r_col_cnt + CNT_W'(1);
                case (r_state)
                    S_FIRST: begin
                        r_hold  <= w_vmax;
                        r_state <= S_SECOND;
                    end
                    default: begin
                        output_column <= w_pool;
                        valid_out     <= 1'b1;
                        last_out      <= (r_col_cnt == LAST_COL);
                        r_state       <= S_FIRST;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool2_col.sv
// tb/tb_relu_maxpool2_col.sv - directed self-checking bench for relu_maxpool2_col
module tb_relu_maxpool2_col;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              valid_in;
    logic [9:0][15:0]  input_column;
    logic [4:0][15:0]  output_column;
    logic              valid_out;
    logic              last_out;

    int n_checks = 0;
    int n_fail   = 0;

    relu_maxpool2_col dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .valid_in      (valid_in),
        .input_column  (input_column),
        .output_column (output_column),
        .valid_out     (valid_out),
        .last_out      (last_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input; returns at the next negedge so outputs are settled.
    task automatic cyc(input logic v, input logic [159:0] c);
        valid_in     = v;
        input_column = c;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic run_map(input logic [15:0] base, input string tag);
        logic [15:0] val;
        for (int i = 0; i < 10; i++) begin
            val = base + 16'(i);
            cyc(1'b1, {10{val}});
            check_eq({tag, "_vld"}, 80'(valid_out), 80'(i % 2));
            check_eq({tag, "_last"}, 80'(last_out), 80'(i == 9));
            if (i % 2 == 1)
                check_eq({tag, "_data"}, output_column, {5{val}});
        end
    endtask

    logic [9:0][15:0] ca, cb;
    logic [79:0]      exp_a, exp_b;

    initial begin
        clk = 1'b0; rst = 1'b0; clear = 1'b0; valid_in = 1'b0; input_column = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_data", output_column, 80'h0);
        check_eq("rst_vld", 80'(valid_out), 80'h0);
        check_eq("rst_last", 80'(last_out), 80'h0);
        rst = 1'b1;
        @(negedge clk);

        ca = '{16'h8000, 16'h0000, 16'h7BFF, 16'h7E00, 16'hC200,
               16'hC400, 16'h8005, 16'h0001, 16'hBC00, 16'h3C00};
        cb = '{16'h8000, 16'h8000, 16'h3C00, 16'h3C00, 16'h8000,
               16'hC500, 16'h0000, 16'h8001, 16'hC000, 16'h4000};
`ifdef MAXPOOL_RELU_EN
        exp_a = {16'h0000, 16'h7E00, 16'h0000, 16'h0001, 16'h4000};
        exp_b = 80'h0;
`else
        exp_a = {16'h0000, 16'h7E00, 16'h8000, 16'h0001, 16'h4000};
        exp_b = {5{16'hC400}};
`endif
        cyc(1'b1, ca);
        check_eq("pool_c0_vld", 80'(valid_out), 80'h0);
        cyc(1'b1, cb);
        check_eq("pool_vld", 80'(valid_out), 80'h1);
        check_eq("pool_last", 80'(last_out), 80'h0);
        check_eq("pool_data", output_column, exp_a);
        cyc(1'b0, '0);
        check_eq("pool_idle_vld", 80'(valid_out), 80'h0);
        check_eq("pool_hold", output_column, exp_a);

        cyc(1'b1, {10{16'hC400}});
        cyc(1'b1, {10{16'hC400}});
        check_eq("neg_vld", 80'(valid_out), 80'h1);
        check_eq("neg_data", output_column, exp_b);

        clear = 1'b1;
        cyc(1'b0, '0);
        clear = 1'b0;
        run_map(16'h1000, "map1");

        cyc(1'b1, {10{16'h7000}});
        check_eq("col11_vld", 80'(valid_out), 80'h0);
        clear = 1'b1;
        cyc(1'b1, {10{16'h7100}});
        clear = 1'b0;
        check_eq("clr_vld", 80'(valid_out), 80'h0);
        check_eq("clr_hold", output_column, {5{16'h1009}});
        run_map(16'h2000, "map2");

        cyc(1'b1, {10{16'h5000}});
        rst = 1'b0;
        #1;
        check_eq("mid_rst_data", output_column, 80'h0);
        check_eq("mid_rst_vld", 80'(valid_out), 80'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, {10{16'h1111}});
        check_eq("post_rst_c0_vld", 80'(valid_out), 80'h0);
        cyc(1'b1, {10{16'h2222}});
        check_eq("post_rst_vld", 80'(valid_out), 80'h1);
        check_eq("post_rst_data", output_column, {5{16'h2222}});

        cyc(1'b1, {10{16'h3000}});
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, {10{16'h7777}});
            check_eq("gap_vld", 80'(valid_out), 80'h0);
        end
        cyc(1'b1, {10{16'h2000}});
        check_eq("gap_pulse", 80'(valid_out), 80'h1);
        check_eq("gap_last", 80'(last_out), 80'h0);
        check_eq("gap_data", output_column, {5{16'h3000}});
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0);
            check_eq("gap_idle_vld", 80'(valid_out), 80'h0);
            check_eq("gap_hold", output_column, {5{16'h3000}});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/relu_maxpool2_col.md
RELU_MAXPOOL2_COL -- requirements
Module: relu_maxpool2_col

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, FP16 element width.
REQ-002 SHALL have parameter INPUT_COL_SIZE, default 10, elements per input column (equal to the upstream conv channel's PARALLEL_UNITS).
REQ-003 SHALL have parameter NUM_COLS, default 10, columns per feature map; it SHALL be even and at least 2.
REQ-004 SHALL have localparam OUT_COL_SIZE = INPUT_COL_SIZE/2 (floor).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port clear, input, 1, synchronous restart of pairing and column count.
REQ-008 SHALL have port valid_in, input, 1, input_column is valid this cycle.
REQ-009 SHALL have port input_column, input, [DATA_WIDTH-1:0] x INPUT_COL_SIZE, FP16 conv output column.
REQ-010 SHALL have port output_column, output, [DATA_WIDTH-1:0] x OUT_COL_SIZE, pooled column.
REQ-011 SHALL have port valid_out, output, 1, one-cycle pulse qualifying output_column.
REQ-012 SHALL have port last_out, output, 1, asserted with valid_out for the final pooled column of a map.

Function
REQ-013 SHALL, with activation enabled, map each element with sign bit 1 (including -0) to 16'h0000 and pass all other elements unchanged.
REQ-014 SHALL form the vertical max v[k] = max(e[2k], e[2k+1]) for k = 0..OUT_COL_SIZE-1; for odd INPUT_COL_SIZE, the last row SHALL be dropped.
REQ-015 SHALL compare post-ReLU values as unsigned 16-bit patterns; a positive NaN compares greater than all finite values.
REQ-016 SHALL implement FSM states S_FIRST and S_SECOND; reset state is S_FIRST.
REQ-017 SHALL, in S_FIRST with valid_in, store v[] in a hold register and go to S_SECOND; no output.
REQ-018 SHALL, in S_SECOND with valid_in, register max(hold[k], v[k]) into output_column, pulse valid_out the next cycle (latency 1), and return to S_FIRST.
REQ-019 SHALL make no state change when valid_in is low; gaps of any length between columns are allowed.
REQ-020 SHALL count accepted columns 0..NUM_COLS-1 and wrap to 0 after NUM_COLS-1; last_out = 1 with the valid_out produced by column NUM_COLS-1.
REQ-021 SHALL hold output_column between valid_out pulses; valid_out and last_out are low otherwise.
REQ-022 SHALL, when clear is high, force S_FIRST and column count 0 at the next edge; clear has priority over a simultaneous valid_in, which is dropped, and also suppresses a valid_out pending from that cycle's input.
REQ-023 SHALL accept back-to-back valid_in every cycle with no stall (full throughput, no backpressure).

Reset
REQ-024 SHALL, on rst low, asynchronously set state S_FIRST, column count 0, hold register 0, output_column all 0, valid_out 0, last_out 0.
REQ-025 SHALL discard any half-formed pair on reset mid-map; the first column after reset is treated as column 0.

Configuration
REQ-026 SHALL, when macro MAXPOOL_RELU_EN is defined, apply REQ-013 before pooling.
REQ-027 SHALL, when MAXPOOL_RELU_EN is undefined, omit ReLU and use a full FP16 signed compare: negative < +/-0 < positive; -0 and +0 are equal, first operand kept; larger-magnitude negative is smaller.

Verification
REQ-028 SHALL verify ReLU pool: col0 rows {3C00,BC00,...}, col1 {4000,C000,...} -> out[0]=4000 one cycle after col1 valid_in, valid_out=1.
REQ-029 SHALL verify all-negative input: both columns all C400 -> with MAXPOOL_RELU_EN, out all 0000; without it, out all C400.
REQ-030 SHALL verify last_out: 10 columns back-to-back -> 5 valid_out pulses on alternate cycles, last_out only on the 5th; the 11th column starts a new pair.
REQ-031 SHALL verify clear: col0, then clear with col1 in the same cycle -> no valid_out; the next two columns pool normally with last_out count restarted.
REQ-032 SHALL verify reset mid-pair: col0 accepted, rst low for 1 cycle -> outputs 0; the next two columns form a fresh pair.
REQ-033 SHALL verify gaps: col0, 5 idle cycles, col1 -> a single valid_out with the correct max; output_column holds until the next pulse.
